burst_rr_arbiter: RTL and testbench

- Shares the single BRAM output FIFO between all readout sources: the 8 Timepix3 RX channel FIFOs, the timestamp FIFO and the count FIFO.
- Uses round-robin arbitration with bursts. A granted source may move up to MAX_BURST consecutive words before ownership rotates, so one busy chip cannot monopolise the output.
- Sits between the first-word-fall-through source FIFOs and the output FIFO. A one-entry registered output stage decouples it from the output FIFO read strobe.

---
 rtl/burst_rr_arbiter_pkg.sv | 25 ++
 rtl/burst_rr_arbiter_pick.sv | 40 ++++
 rtl/burst_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_burst_rr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_rr_arbiter_pkg.sv
// Shared definitions for the readout burst arbiter: state encoding,
// default sizing and the fixed assignment of readout sources to indices.
package burst_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 16;

  // Source index map: count FIFO, timestamp FIFO, then the 8 RX channels.
  localparam int SRC_COUNT     = 0;
  localparam int SRC_TIMESTAMP = 1;
  localparam int SRC_RX_BASE   = 2;
  localparam int NUM_RX        = 8;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_rr_arbiter_pick.sv
// Rotating priority encoder: finds the first set bit of act, starting the
// search at ptr and wrapping from WIDTH-1 back to 0.
module rr_priority_pick
  import burst_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IW   = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] act,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic [IW-1:0]    cand [WIDTH];
  logic [WIDTH-1:0] hit;

  // Candidate gi is the source gi places after ptr in rotating order.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum       = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi]  = (sum >= (IW+1)'(WIDTH)) ? IW'(sum - (IW+1)'(WIDTH)) : sum[IW-1:0];
      assign hit[gi]   = act[cand[gi]];
    end
  endgenerate

  // Lowest rotating position with a hit wins; scan downward so it overrides.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin burst arbiter sharing the output FIFO between the readout
// source FIFOs. A granted source may move up to MAX_BURST words per tenure;
// a one-entry output register decouples the sources from the read strobe.
module burst_rr_arbiter
  import burst_rr_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  localparam int IW        = idx_w(WIDTH)
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic [WIDTH-1:0]            EN,
  input  logic [WIDTH-1:0]            REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0]            GRANT,
  input  logic                        READ_OUT,
  output logic                        VALID_OUT,
  output logic [DATA_WIDTH-1:0]       DATA_OUT,
  output logic [IW-1:0]               OWNER,
  output logic                        BUSY
);

  arb_state_t            state_reg, state_next;
  logic [IW-1:0]         owner_reg, owner_next;
  logic [IW-1:0]         ptr_reg, ptr_next;
  logic [7:0]            burst_cnt_reg, burst_cnt_next;
  logic                  valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;

  logic [WIDTH-1:0]      act;
  logic                  load_ok;
  logic                  owner_act;
  logic                  grant_fire;
  logic [8:0]            cnt_inc;
  logic                  last_word;
  logic [IW-1:0]         next_ptr;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] src_word [WIDTH];

  assign act        = REQ & EN;
  assign load_ok    = ~valid_reg | READ_OUT;
  assign owner_act  = act[owner_reg];
  // Reset gating keeps the pop strobes quiet for the whole reset pulse.
  assign grant_fire = (state_reg == BURST) & load_ok & owner_act & ~BUS_RST;
  assign cnt_inc    = {1'b0, burst_cnt_reg} + 9'd1;
  assign last_word  = (cnt_inc == 9'(MAX_BURST));
  assign next_ptr   = (owner_reg == IW'(WIDTH - 1)) ? '0 : owner_reg + 1'b1;

  // Per-source word slices and one-hot pop strobes.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_src
      assign src_word[gi] = DATA_IN[gi*DATA_WIDTH +: DATA_WIDTH];
      assign GRANT[gi]    = grant_fire & (owner_reg == IW'(gi));
    end
  endgenerate

  rr_priority_pick #(.WIDTH(WIDTH)) u_pick (
    .act   (act),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: output stage load/consume, tenure start and exit.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    valid_next     = valid_reg;
    data_next      = data_reg;

    // The output stage drains in any state; a new word may replace a consumed one.
    if (grant_fire) begin
      data_next      = src_word[owner_reg];
      valid_next     = 1'b1;
      burst_cnt_next = (burst_cnt_reg == 8'hFF) ? burst_cnt_reg : cnt_inc[7:0];
    end else if (READ_OUT) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next     = BURST;
          owner_next     = pick_idx;
          burst_cnt_next = 8'd0;
        end
      end
      BURST: begin
        if ((grant_fire && last_word) || !owner_act) begin
          state_next = IDLE;
          ptr_next   = next_ptr;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      burst_cnt_reg <= 8'd0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      ptr_reg       <= ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      valid_reg     <= valid_next;
      data_reg      <= data_next;
    end
  end

  assign VALID_OUT = valid_reg;
  assign DATA_OUT  = data_reg;
  assign OWNER     = owner_reg;
  assign BUSY      = (state_reg == BURST);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Scoreboard bench for burst_rr_arbiter: source FIFOs are modelled as
// queues, expected output words come from a round-robin tenure model.
module tb_burst_rr_arbiter;
  import burst_rr_arbiter_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int MB = DEF_MAX_BURST;
  localparam int IW = idx_w(W);

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      EN, REQ, GRANT;
  logic [W*DW-1:0]   DATA_IN;
  logic              READ_OUT, VALID_OUT, BUSY;
  logic [DW-1:0]     DATA_OUT;
  logic [IW-1:0]     OWNER;

  always #5 clk = ~clk;

  burst_rr_arbiter dut (
    .BUS_CLK  (clk),
    .BUS_RST  (rst),
    .EN       (EN),
    .REQ      (REQ),
    .DATA_IN  (DATA_IN),
    .GRANT    (GRANT),
    .READ_OUT (READ_OUT),
    .VALID_OUT(VALID_OUT),
    .DATA_OUT (DATA_OUT),
    .OWNER    (OWNER),
    .BUSY     (BUSY)
  );

  logic [DW-1:0] src_q [W][$];
  logic [DW-1:0] exp_q[$];
  int            exp_bo[$], exp_bl[$];
  logic [W-1:0]  log_g[$];
  logic          log_b[$], log_v[$];
  logic [IW-1:0] log_o[$];
  logic          log_en = 1'b0;
  logic [W-1:0]  en_v;
  int            rd_mode;
  logic [W-1:0]  g_s;
  logic [DW-1:0] mon_exp;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input bit ok, input string name, input longint got, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, req);
    end
  endtask

  // Drive source FIFO heads, enables and read strobe.
  task automatic refresh();
    for (int i = 0; i < W; i++) begin
      REQ[i] = (src_q[i].size() != 0);
      DATA_IN[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
    EN = en_v;
    READ_OUT = (rd_mode == 0) ? 1'b1 : (rd_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
  endtask

  // One clock cycle: sample on the falling edge, pop granted FIFOs after the rising edge.
  task automatic tick();
    refresh();
    @(negedge clk);
    #1;
    g_s = GRANT;
    check(((GRANT & ~(REQ & EN)) == '0) && $onehot0(GRANT), "grant_legal", GRANT, REQ & EN);
    if (log_en) begin
      log_g.push_back(GRANT);
      log_b.push_back(BUSY);
      log_v.push_back(VALID_OUT);
      log_o.push_back(OWNER);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++)
      if (g_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
  endtask

  task automatic load(input int s, input int n);
    for (int m = 0; m < n; m++) src_q[s].push_back({4'(s), 28'($urandom)});
  endtask

  task automatic clear_all();
    for (int i = 0; i < W; i++) src_q[i].delete();
    exp_q.delete(); exp_bo.delete(); exp_bl.delete();
    log_g.delete(); log_b.delete(); log_v.delete(); log_o.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en_v = '1;
    rd_mode = 0;
    clear_all();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Tenure-level model: rotate from ptr over enabled non-empty sources,
  // each tenure moving min(MAX_BURST, remaining) words.
  task automatic model_round(input logic [W-1:0] en, input int start_ptr, output int end_ptr);
    int rem[W];
    int pos[W];
    int p, j, n;
    p = start_ptr;
    for (int i = 0; i < W; i++) begin
      rem[i] = src_q[i].size();
      pos[i] = 0;
    end
    forever begin
      j = -1;
      for (int k = 0; k < W; k++) begin
        if (j < 0 && en[(p + k) % W] && rem[(p + k) % W] > 0) j = (p + k) % W;
      end
      if (j < 0) break;
      n = (rem[j] < MB) ? rem[j] : MB;
      for (int m = 0; m < n; m++) exp_q.push_back(src_q[j][pos[j] + m]);
      exp_bo.push_back(j);
      exp_bl.push_back(n);
      pos[j] += n;
      rem[j] -= n;
      p = (j + 1) % W;
    end
    end_ptr = p;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  // Split the grant log into (owner, run length) tenures and compare to the model.
  task automatic check_bursts(input string name);
    int obo[$], obl[$];
    int cur, o;
    cur = -1;
    foreach (log_g[k]) begin
      if (log_g[k] == '0) cur = -1;
      else begin
        o = $clog2(log_g[k]);
        if (o == cur) obl[obl.size() - 1]++;
        else begin
          obo.push_back(o);
          obl.push_back(1);
          cur = o;
        end
      end
    end
    check(obo.size() == exp_bo.size(), {name, "_count"}, obo.size(), exp_bo.size());
    for (int i = 0; i < obo.size() && i < exp_bo.size(); i++)
      check(obo[i] == exp_bo[i] && obl[i] == exp_bl[i], name,
            obo[i] * 1000 + obl[i], exp_bo[i] * 1000 + exp_bl[i]);
    log_g.delete(); log_b.delete(); log_v.delete(); log_o.delete();
    exp_bo.delete(); exp_bl.delete();
    log_en = 1'b0;
  endtask

  // Monitor: every consumed output word must be the next scoreboard entry.
  always @(negedge clk) begin
    #2;
    if (!rst && VALID_OUT && READ_OUT) begin
      if (exp_q.size() == 0) check(1'b0, "unexpected_word", DATA_OUT, 0);
      else begin
        mon_exp = exp_q.pop_front();
        check(DATA_OUT == mon_exp, "data_order", DATA_OUT, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p, mism, pos, rem, n, ng, c;
    logic [DW-1:0] w0, w1;
    logic          pat [50];
    logic [W-1:0]  one3;

    rst = 1'b1; en_v = '1; rd_mode = 0;
    REQ = '0; EN = '1; DATA_IN = '0; READ_OUT = 1'b0;
    do_reset();
    check(VALID_OUT == 1'b0, "rst_valid", VALID_OUT, 0);
    check(DATA_OUT == '0, "rst_data", DATA_OUT, 0);
    check(OWNER == '0, "rst_owner", OWNER, 0);
    check(BUSY == 1'b0, "rst_busy", BUSY, 0);
    check(GRANT == '0, "rst_grant", GRANT, 0);

    // Single source, 40 words: bursts 16/16/8 with one-cycle bubbles.
    log_en = 1'b1;
    load(3, 40);
    model_round(en_v, 0, p);
    repeat (50) tick();
    for (int k = 0; k < 50; k++) pat[k] = 1'b0;
    pos = 1; rem = 40;
    while (rem > 0) begin
      n = (rem < MB) ? rem : MB;
      for (int m = 0; m < n; m++) if (pos + m < 50) pat[pos + m] = 1'b1;
      pos += n + 1;
      rem -= n;
    end
    one3 = '0; one3[3] = 1'b1;
    mism = 0;
    for (int k = 0; k < 50; k++) begin
      if (log_g[k] != (pat[k] ? one3 : '0)) mism++;
      if (log_b[k] && log_o[k] != 3) mism++;
    end
    check(mism == 0, "t1_grant_pattern", mism, 0);
    check(log_b[0] == 1'b0 && log_b[1] == 1'b1, "t1_busy_latency", {log_b[0], log_b[1]}, 1);
    check(log_v[1] == 1'b0 && log_v[2] == 1'b1, "t1_valid_latency", {log_v[1], log_v[2]}, 1);
    check_bursts("t1_bursts");
    check(exp_q.size() == 0, "t1_all_words", exp_q.size(), 0);

    // Fairness between 0, 5 and 9.
    do_reset();
    log_en = 1'b1;
    load(0, 40); load(5, 40); load(9, 40);
    model_round(en_v, 0, p);
    wait_drain(500);
    check_bursts("t2_order");

    // Backpressure on the output stage.
    do_reset();
    rd_mode = 2;
    load(6, 5);
    w0 = src_q[6][0];
    w1 = src_q[6][1];
    model_round(en_v, 0, p);
    tick();
    tick();
    check(g_s[6] == 1'b1, "t3_first_grant", g_s, 64);
    check(VALID_OUT == 1'b1 && DATA_OUT == w0, "t3_first_word", DATA_OUT, w0);
    mism = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (g_s != '0 || VALID_OUT != 1'b1 || DATA_OUT != w0) mism++;
    end
    check(mism == 0, "t3_stall_hold", mism, 0);
    rd_mode = 0;
    tick();
    check(g_s[6] == 1'b1, "t3_resume_grant", g_s, 64);
    check(VALID_OUT == 1'b1 && DATA_OUT == w1, "t3_next_word", DATA_OUT, w1);
    wait_drain(100);

    // Masked source 2, then source 4 disabled mid-burst.
    do_reset();
    en_v[2] = 1'b0;
    load(2, 5);
    load(4, 40);
    for (int m = 0; m < 5; m++) exp_q.push_back(src_q[4][m]);
    ng = 0; c = 0;
    while (ng < 5 && c < 50) begin
      tick();
      if (g_s[4]) ng++;
      c++;
    end
    check(ng == 5, "t4_grants_before_mask", ng, 5);
    en_v[4] = 1'b0;
    load(5, 3);
    load(3, 3);
    for (int m = 0; m < 3; m++) exp_q.push_back(src_q[5][m]);
    for (int m = 0; m < 3; m++) exp_q.push_back(src_q[3][m]);
    tick();
    check(g_s == '0, "t4_grant_drop", g_s, 0);
    check(BUSY == 1'b0, "t4_idle_after_mask", BUSY, 0);
    tick();
    check(BUSY == 1'b1 && OWNER == 5, "t4_ptr_next_owner", OWNER, 5);
    wait_drain(200);

    // Drain: source 7 with 3 words, then PTR must point at 8.
    do_reset();
    load(7, 3);
    model_round(en_v, 0, p);
    ng = 0; mism = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (g_s[7]) ng++;
      if ((g_s & ~(W'(1) << 7)) != '0) mism++;
    end
    check(ng == 3 && mism == 0, "t5_drain_grants", ng, 3);
    check(BUSY == 1'b0, "t5_idle", BUSY, 0);
    load(0, 2);
    load(8, 2);
    model_round(en_v, 8, p);
    tick();
    check(BUSY == 1'b1 && OWNER == 8, "t5_ptr_owner", OWNER, 8);
    wait_drain(100);

    // Asynchronous reset in the middle of a burst.
    load(8, 40);
    for (int m = 0; m < 40; m++) exp_q.push_back(src_q[8][m]);
    repeat (4) tick();
    check(BUSY == 1'b1 && VALID_OUT == 1'b1, "t6_pre_reset", {BUSY, VALID_OUT}, 3);
    #3;
    rst = 1'b1;
    #1;
    check(VALID_OUT == 1'b0 && BUSY == 1'b0 && GRANT == '0, "t6_async_drop",
          {VALID_OUT, BUSY, GRANT}, 0);
    clear_all();
    refresh();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(OWNER == '0 && BUSY == 1'b0 && VALID_OUT == 1'b0, "t6_after_release", OWNER, 0);
    load(0, 3);
    load(5, 3);
    model_round(en_v, 0, p);
    tick();
    check(BUSY == 1'b1 && OWNER == 0, "t6_ptr_reset", OWNER, 0);
    wait_drain(100);

    // Randomized rounds against the tenure model.
    do_reset();
    p = 0;
    for (int r = 0; r < 8; r++) begin
      en_v = W'($urandom);
      if (r % 2 == 1) en_v[2] = 1'b0;
      for (int s = 0; s < W; s++) load(s, $urandom_range(0, 30));
      rd_mode = $urandom_range(0, 1);
      model_round(en_v, p, p);
      wait_drain(3000);
      mism = 0;
      for (int s = 0; s < W; s++) if (en_v[s] && src_q[s].size() != 0) mism++;
      check(mism == 0, "rand_sources_empty", mism, 0);
      for (int s = 0; s < W; s++) src_q[s].delete();
      exp_bo.delete(); exp_bl.delete();
      rd_mode = 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
